// File: rtl/icache_line_fill_ctrl.sv
// icache_line_fill_ctrl
// Moves one cache line (refill) or the whole cache (prefill) from the
// application Wishbone burst port into the icache SRAM. On a refill the word
// the CPU is waiting for is forwarded as soon as its beat arrives. The line
// stays invalid while it fills, and its tag is only written on a clean last
// beat.
// Optional feature macro: ICACHE_PREFILL_EN. When defined, a prefill request
// loads every line starting at address 0. When not defined, prefill requests
// are ignored.
module icache_line_fill_ctrl #(
  parameter int WB_AW      = 32,
  parameter int WB_DW      = 32,
  parameter int CACHELINES = 16,
  parameter int LINE_WORDS = 32,
  parameter int TAG_W      = 20,
  localparam int OFS_W  = $clog2(CACHELINES),
  localparam int PTR_W  = $clog2(LINE_WORDS),
  localparam int MEM_AW = OFS_W + PTR_W
) (
  input  logic                 mclk,
  input  logic                 rst_n,
  // CPU side
  input  logic [WB_AW-1:0]     cpu_addr,
  output logic [WB_DW-1:0]     cpu_dat_o,
  output logic                 cpu_ack_o,
  output logic                 cpu_err_o,
  // application Wishbone burst port
  output logic                 app_stb_o,
  output logic [WB_AW-1:0]     app_adr_o,
  output logic                 app_we_o,
  output logic [WB_DW/8-1:0]   app_sel_o,
  output logic [15:0]          app_bl_o,
  input  logic [WB_DW-1:0]     app_dat_i,
  input  logic                 app_ack_i,
  input  logic                 app_lack_i,
  input  logic                 app_err_i,
  // tag RAM
  input  logic [OFS_W-1:0]     tag_cur_loc,
  output logic                 tag_uwr,
  output logic                 tag_wr,
  output logic [OFS_W-1:0]     tag_uptr,
  output logic [TAG_W:0]       tag_wdata,
  // data SRAM (active-low controls)
  output logic                 mem_csb0,
  output logic                 mem_web0,
  output logic [MEM_AW-1:0]    mem_addr0,
  output logic [WB_DW/8-1:0]   mem_wmask0,
  output logic [WB_DW-1:0]     mem_din0,
  // cache control
  input  logic                 cache_refill_req,
  input  logic                 cache_prefill_req,
  output logic                 cache_busy
);

  localparam logic [15:0] BL_LINE = 16'(LINE_WORDS);
`ifdef ICACHE_PREFILL_EN
  localparam logic [15:0]      BL_CACHE = 16'(LINE_WORDS * CACHELINES);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LINE_WORDS - 1);
`endif

`ifdef ICACHE_PREFILL_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REFILL  = 2'd1,
    ST_PREFILL = 2'd2,
    ST_DONE    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REFILL  = 2'd1,
    ST_DONE    = 2'd3
  } state_t;
`endif

  state_t              state_q,     state_d;
  logic [PTR_W-1:0]    ptr_q,       ptr_d;
  logic [OFS_W-1:0]    offset_q,    offset_d;
  logic                fwd_q,       fwd_d;
  logic                busy_q,      busy_d;
  logic                stb_q,       stb_d;
  logic [WB_AW-1:0]    adr_q,       adr_d;
  logic [15:0]         bl_q,        bl_d;
  logic [WB_DW-1:0]    cpu_dat_q,   cpu_dat_d;
  logic                cpu_ack_q,   cpu_ack_d;
  logic                cpu_err_q,   cpu_err_d;
  logic                tag_uwr_q,   tag_uwr_d;
  logic                tag_wr_q,    tag_wr_d;
  logic [OFS_W-1:0]    tag_uptr_q,  tag_uptr_d;
  logic [TAG_W:0]      tag_wdata_q, tag_wdata_d;
  logic                csb_q,       csb_d;
  logic                web_q,       web_d;
  logic [MEM_AW-1:0]   mem_addr_q,  mem_addr_d;
  logic [WB_DW-1:0]    mem_din_q,   mem_din_d;

  // Fields of the CPU fetch address: word within the line, tag, line base.
  logic [PTR_W-1:0]    cpu_word;
  logic [TAG_W-1:0]    cpu_tag;
  logic [WB_AW-1:0]    line_adr;
  logic                in_refill;

  assign cpu_word  = cpu_addr[PTR_W+1:2];
  assign cpu_tag   = cpu_addr[PTR_W+2+TAG_W-1:PTR_W+2];
  assign line_adr  = {cpu_addr[WB_AW-1:PTR_W+2], {(PTR_W+2){1'b0}}};
  assign in_refill = (state_q == ST_REFILL);

`ifdef ICACHE_PREFILL_EN
  logic in_prefill;
  assign in_prefill = (state_q == ST_PREFILL);
`endif

  // Byte-lane qualifiers and the write-enable mirror registered controls.
  assign app_we_o   = 1'b0;
  assign app_sel_o  = {(WB_DW/8){stb_q}};
  assign mem_wmask0 = {(WB_DW/8){~web_q}};

  assign cpu_dat_o  = cpu_dat_q;
  assign cpu_ack_o  = cpu_ack_q;
  assign cpu_err_o  = cpu_err_q;
  assign app_stb_o  = stb_q;
  assign app_adr_o  = adr_q;
  assign app_bl_o   = bl_q;
  assign tag_uwr    = tag_uwr_q;
  assign tag_wr     = tag_wr_q;
  assign tag_uptr   = tag_uptr_q;
  assign tag_wdata  = tag_wdata_q;
  assign mem_csb0   = csb_q;
  assign mem_web0   = web_q;
  assign mem_addr0  = mem_addr_q;
  assign mem_din0   = mem_din_q;
  assign cache_busy = busy_q;

  // Byte-offset bits never select anything; prefill request is dead without the feature.
  logic unused_ok;
`ifdef ICACHE_PREFILL_EN
  assign unused_ok = &{1'b0, cpu_addr[1:0]};
`else
  assign unused_ok = &{1'b0, cpu_addr[1:0], cache_prefill_req};
`endif

  // Next-state and next-output computation for the fill sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    offset_d    = offset_q;
    fwd_d       = fwd_q;
    busy_d      = busy_q;
    stb_d       = stb_q;
    adr_d       = adr_q;
    bl_d        = bl_q;
    cpu_dat_d   = cpu_dat_q;
    tag_uptr_d  = tag_uptr_q;
    tag_wdata_d = tag_wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    // single-cycle strobes drop unless re-raised below
    cpu_ack_d   = 1'b0;
    cpu_err_d   = 1'b0;
    tag_uwr_d   = 1'b0;
    tag_wr_d    = 1'b0;
    csb_d       = 1'b1;
    web_d       = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cache_refill_req) begin
          // Invalidate the victim first so no hit can see a half-filled line.
          state_d     = ST_REFILL;
          busy_d      = 1'b1;
          stb_d       = 1'b1;
          adr_d       = line_adr;
          bl_d        = BL_LINE;
          tag_uwr_d   = 1'b1;
          tag_uptr_d  = tag_cur_loc;
          tag_wdata_d = '0;
          offset_d    = tag_cur_loc;
          ptr_d       = '0;
          fwd_d       = 1'b0;
        end
`ifdef ICACHE_PREFILL_EN
        else if (cache_prefill_req) begin
          state_d  = ST_PREFILL;
          busy_d   = 1'b1;
          stb_d    = 1'b1;
          adr_d    = '0;
          bl_d     = BL_CACHE;
          offset_d = '0;
          ptr_d    = '0;
          fwd_d    = 1'b0;
        end
`endif
      end

`ifdef ICACHE_PREFILL_EN
      ST_REFILL, ST_PREFILL: begin
`else
      ST_REFILL: begin
`endif
        if (app_err_i) begin
          // Bus error wins over everything: the line is left invalid.
          stb_d   = 1'b0;
          state_d = ST_DONE;
          if (in_refill && !fwd_q) begin
            cpu_err_d = 1'b1;
          end
        end else begin
          if (app_ack_i) begin
            csb_d      = 1'b0;
            web_d      = 1'b0;
            mem_addr_d = {offset_q, ptr_q};
            mem_din_d  = app_dat_i;
            ptr_d      = ptr_q + PTR_W'(1);
            if (in_refill && (ptr_q == cpu_word)) begin
              cpu_ack_d = 1'b1;
              cpu_dat_d = app_dat_i;
              fwd_d     = 1'b1;
            end
`ifdef ICACHE_PREFILL_EN
            // Each completed line during prefill gets the line index as its tag.
            if (in_prefill && (ptr_q == PTR_LAST)) begin
              tag_wr_d    = 1'b1;
              tag_uptr_d  = offset_q;
              tag_wdata_d = {1'b1, TAG_W'(offset_q)};
              offset_d    = offset_q + OFS_W'(1);
            end
`endif
          end
          if (app_lack_i) begin
            stb_d   = 1'b0;
            state_d = ST_DONE;
            if (in_refill) begin
              tag_wr_d    = 1'b1;
              tag_uptr_d  = offset_q;
              tag_wdata_d = {1'b1, cpu_tag};
            end
          end
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        stb_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        stb_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and every output register; reset returns the block to idle at once.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      offset_q    <= '0;
      fwd_q       <= 1'b0;
      busy_q      <= 1'b0;
      stb_q       <= 1'b0;
      adr_q       <= '0;
      bl_q        <= '0;
      cpu_dat_q   <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      tag_uwr_q   <= 1'b0;
      tag_wr_q    <= 1'b0;
      tag_uptr_q  <= '0;
      tag_wdata_q <= '0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      offset_q    <= offset_d;
      fwd_q       <= fwd_d;
      busy_q      <= busy_d;
      stb_q       <= stb_d;
      adr_q       <= adr_d;
      bl_q        <= bl_d;
      cpu_dat_q   <= cpu_dat_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_err_q   <= cpu_err_d;
      tag_uwr_q   <= tag_uwr_d;
      tag_wr_q    <= tag_wr_d;
      tag_uptr_q  <= tag_uptr_d;
      tag_wdata_q <= tag_wdata_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
    end
  end

endmodule

// File: tb/tb_icache_line_fill_ctrl.sv
// tb_icache_line_fill_ctrl
// Scoreboard bench: the stimulus tasks push the responses a line-fill
// controller must produce (burst request, invalidate, SRAM writes, CPU
// forward/error, tag write) into queues; a monitor pops them as the DUT
// raises the corresponding outputs.
module tb_icache_line_fill_ctrl;

  logic        mclk;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_dat_o;
  logic        cpu_ack_o;
  logic        cpu_err_o;
  logic        app_stb_o;
  logic [31:0] app_adr_o;
  logic        app_we_o;
  logic [3:0]  app_sel_o;
  logic [15:0] app_bl_o;
  logic [31:0] app_dat_i;
  logic        app_ack_i;
  logic        app_lack_i;
  logic        app_err_i;
  logic [3:0]  tag_cur_loc;
  logic        tag_uwr;
  logic        tag_wr;
  logic [3:0]  tag_uptr;
  logic [20:0] tag_wdata;
  logic        mem_csb0;
  logic        mem_web0;
  logic [8:0]  mem_addr0;
  logic [3:0]  mem_wmask0;
  logic [31:0] mem_din0;
  logic        cache_refill_req;
  logic        cache_prefill_req;
  logic        cache_busy;

  icache_line_fill_ctrl dut (
    .mclk(mclk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_dat_o(cpu_dat_o), .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o),
    .app_stb_o(app_stb_o), .app_adr_o(app_adr_o), .app_we_o(app_we_o), .app_sel_o(app_sel_o),
    .app_bl_o(app_bl_o), .app_dat_i(app_dat_i), .app_ack_i(app_ack_i), .app_lack_i(app_lack_i),
    .app_err_i(app_err_i), .tag_cur_loc(tag_cur_loc), .tag_uwr(tag_uwr), .tag_wr(tag_wr),
    .tag_uptr(tag_uptr), .tag_wdata(tag_wdata), .mem_csb0(mem_csb0), .mem_web0(mem_web0),
    .mem_addr0(mem_addr0), .mem_wmask0(mem_wmask0), .mem_din0(mem_din0),
    .cache_refill_req(cache_refill_req), .cache_prefill_req(cache_prefill_req),
    .cache_busy(cache_busy)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int n_cmp  = 0;
  int n_fail = 0;

  // expected-response queues
  logic [63:0] q_req[$];   // {adr, 16'h0, bl}
  logic [63:0] q_uwr[$];   // {uptr, wdata}
  logic [63:0] q_wr[$];    // {uptr, wdata}
  logic [63:0] q_mem[$];   // {addr, data}
  logic [63:0] q_cpu[$];   // {err, data}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name, input logic [63:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: unexpected output %h, none required", name, act);
  endtask

  // Monitor: pops an expectation for every output event the DUT presents.
  logic stb_prev = 1'b0;
  always @(negedge mclk) begin
    if (!rst_n) begin
      stb_prev = 1'b0;
    end else begin
      if (app_stb_o && !stb_prev) begin
        if (q_req.size() == 0) unexp("burst_req", {app_adr_o, 16'h0, app_bl_o});
        else chk("burst_req", {app_adr_o, 16'h0, app_bl_o}, q_req.pop_front());
        chk("burst_sel_we", {app_sel_o, app_we_o}, {4'hF, 1'b0});
      end
      stb_prev = app_stb_o;
      if (tag_uwr) begin
        if (q_uwr.size() == 0) unexp("tag_uwr", 64'({tag_uptr, tag_wdata}));
        else chk("tag_uwr", 64'({tag_uptr, tag_wdata}), q_uwr.pop_front());
      end
      if (tag_wr) begin
        if (q_wr.size() == 0) unexp("tag_wr", 64'({tag_uptr, tag_wdata}));
        else chk("tag_wr", 64'({tag_uptr, tag_wdata}), q_wr.pop_front());
      end
      if (!mem_csb0) begin
        if (q_mem.size() == 0) unexp("sram_wr", 64'({mem_addr0, mem_din0}));
        else chk("sram_wr", 64'({mem_addr0, mem_din0}), q_mem.pop_front());
        chk("sram_web_mask", 64'({mem_web0, mem_wmask0}), 64'({1'b0, 4'hF}));
      end
      if (cpu_ack_o) begin
        if (q_cpu.size() == 0) unexp("cpu_ack", 64'({1'b0, cpu_dat_o}));
        else chk("cpu_ack", 64'({1'b0, cpu_dat_o}), q_cpu.pop_front());
      end
      if (cpu_err_o) begin
        if (q_cpu.size() == 0) unexp("cpu_err", 64'({1'b1, 32'h0}));
        else chk("cpu_err", 64'({1'b1, 32'h0}), q_cpu.pop_front());
      end
    end
  end

  task automatic chk_reset_vals(input string name);
    chk({name, "_cpu"}, 64'({cpu_dat_o, cpu_ack_o, cpu_err_o}), 64'h0);
    chk({name, "_app"}, 64'({app_stb_o, app_we_o, app_sel_o, app_bl_o, app_adr_o}), 64'h0);
    chk({name, "_tag"}, 64'({tag_uwr, tag_wr, tag_uptr, tag_wdata}), 64'h0);
    chk({name, "_mem"}, 64'({mem_csb0, mem_web0, mem_wmask0, mem_addr0}), 64'({2'b11, 4'h0, 9'h0}));
    chk({name, "_din_busy"}, 64'({mem_din0, cache_busy}), 64'h0);
  endtask

  task automatic wait_busy(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge mclk); #1;
      if (cache_busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_busy_rise"}, 64'(seen), 64'h1);
  endtask

  // Called one cycle after the terminating beat was sampled.
  task automatic end_checks(input string name);
    chk({name, "_done_stb_busy"}, 64'({app_stb_o, cache_busy}), 64'h1);
    @(posedge mclk); #1;
    chk({name, "_busy_fall"}, 64'({app_stb_o, cache_busy}), 64'h0);
  endtask

  // One refill. err_beat<0: no error; stop_after<32 leaves the burst open.
  task automatic do_refill(input logic [31:0] addr, input logic [3:0] loc, input int err_beat,
                           input bit lack_sep, input int gmin, input int gmax, input int stop_after);
    int          word;
    logic [19:0] tg;
    bit          fwd;
    logic [31:0] d;
    word = int'(addr[6:2]);
    tg   = addr[26:7];
    fwd  = 1'b0;
    cpu_addr    = addr;
    tag_cur_loc = loc;
    q_req.push_back({addr & 32'hFFFF_FF80, 16'h0, 16'd32});
    q_uwr.push_back(64'({loc, 21'h0}));
    cache_refill_req = 1'b1;
    wait_busy("refill");
    cache_refill_req = 1'b0;
    tag_cur_loc = 4'($urandom);
    for (int i = 0; i < stop_after; i++) begin
      repeat ($urandom_range(gmax, gmin)) begin @(posedge mclk); #1; end
      if (i == err_beat) begin
        app_err_i = 1'b1;
        if (!fwd) q_cpu.push_back(64'({1'b1, 32'h0}));
        @(posedge mclk); #1;
        app_err_i = 1'b0;
        end_checks("refill_err");
        return;
      end
      d = $urandom;
      app_ack_i  = 1'b1;
      app_dat_i  = d;
      app_lack_i = (i == 31) && !lack_sep;
      q_mem.push_back(64'({9'(int'(loc) * 32 + i), d}));
      if (i == word) begin
        q_cpu.push_back(64'({1'b0, d}));
        fwd = 1'b1;
      end
      if (i == 31 && !lack_sep) q_wr.push_back(64'({loc, 1'b1, tg}));
      @(posedge mclk); #1;
      app_ack_i  = 1'b0;
      app_lack_i = 1'b0;
    end
    if (stop_after < 32) begin
      repeat (2) begin @(posedge mclk); #1; end
      return;
    end
    if (lack_sep) begin
      app_lack_i = 1'b1;
      q_wr.push_back(64'({loc, 1'b1, tg}));
      @(posedge mclk); #1;
      app_lack_i = 1'b0;
    end
    end_checks("refill");
  endtask

`ifdef ICACHE_PREFILL_EN
  task automatic do_prefill();
    logic [31:0] d;
    q_req.push_back({32'h0, 16'h0, 16'd512});
    cache_prefill_req = 1'b1;
    wait_busy("prefill");
    cache_prefill_req = 1'b0;
    for (int i = 0; i < 512; i++) begin
      repeat ($urandom_range(1, 0)) begin @(posedge mclk); #1; end
      d = $urandom;
      app_ack_i  = 1'b1;
      app_dat_i  = d;
      app_lack_i = (i == 511);
      q_mem.push_back(64'({9'(i), d}));
      if (i % 32 == 31) q_wr.push_back(64'({4'(i / 32), 1'b1, 20'(i / 32)}));
      @(posedge mclk); #1;
      app_ack_i  = 1'b0;
      app_lack_i = 1'b0;
    end
    end_checks("prefill");
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          eb;
    int          busy_cnt;
    logic [31:0] ra;
    rst_n = 1'b0;
    cpu_addr = '0; app_dat_i = '0; app_ack_i = 1'b0; app_lack_i = 1'b0; app_err_i = 1'b0;
    tag_cur_loc = '0; cache_refill_req = 1'b0; cache_prefill_req = 1'b0;
    busy_cnt = 0;
    repeat (2) @(posedge mclk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge mclk); #1;
    chk_reset_vals("idle");

    // directed refill: word 19, tag 0x34, victim line 5
    do_refill(32'h0000_1A4C, 4'd5, -1, 1'b0, 0, 0, 32);
    // bus error on beat 3 before word 10 arrives
    do_refill(32'h0000_2028, 4'd9, 3, 1'b0, 0, 1, 32);
    // 2-cycle gaps, ack+lack together on word 31 which is the CPU word
    do_refill(32'h0004_807C, 4'd12, -1, 1'b0, 2, 2, 32);
    // lack on its own cycle after the 32nd beat
    do_refill(32'h00AB_CD10, 4'd0, -1, 1'b1, 0, 1, 32);

    // refill and prefill raised together: refill goes first
    cache_prefill_req = 1'b1;
    do_refill(32'h0000_0F84, 4'd15, -1, 1'b0, 0, 1, 32);
`ifdef ICACHE_PREFILL_EN
    do_prefill();
`else
    repeat (20) begin
      @(posedge mclk); #1;
      if (cache_busy || app_stb_o) busy_cnt++;
    end
    cache_prefill_req = 1'b0;
    chk("prefill_ignored_busy_cycles", 64'(busy_cnt), 64'h0);
`endif

    // reset in the middle of a refill after 7 beats
    do_refill(32'h0000_3350, 4'd3, -1, 1'b0, 0, 0, 7);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    chk("midrst_pending", 64'(q_req.size() + q_uwr.size() + q_wr.size() + q_mem.size() + q_cpu.size()), 64'h0);
    q_req.delete(); q_uwr.delete(); q_wr.delete(); q_mem.delete(); q_cpu.delete();
    repeat (2) @(posedge mclk);
    #1;
    rst_n = 1'b1;
    @(posedge mclk); #1;
    do_refill(32'h0000_3350, 4'd7, -1, 1'b0, 0, 1, 32);

    // randomized refills
    for (int k = 0; k < 8; k++) begin
      ra = $urandom;
      eb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(31, 0)) : -1;
      do_refill(ra, 4'($urandom), eb, 1'($urandom_range(1, 0)), 0, 2, 32);
    end

    repeat (3) @(posedge mclk);
    #1;
    chk("left_req", 64'(q_req.size()), 64'h0);
    chk("left_uwr", 64'(q_uwr.size()), 64'h0);
    chk("left_wr",  64'(q_wr.size()),  64'h0);
    chk("left_mem", 64'(q_mem.size()), 64'h0);
    chk("left_cpu", 64'(q_cpu.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
